// File: rtl/regfile_flags_pkg.sv
// regfile_flags shared package
// Data/address sizing and flag-vector bit positions
package regfile_flags_pkg;

  localparam int DATA_MSB   = 15;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/regfile_flags_if.sv
// regfile_flags datapath bundle
// Master is the CPU core, slave is the register/flag block
interface regfile_flags_if
  import regfile_flags_pkg::*;
#(
  parameter int WIDTH  = DATA_MSB,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH:0]    rd1;
  logic [WIDTH:0]    rd2;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [WIDTH:0]    wd3;
  logic              flag_we;
  logic              carry_in;
  logic              overflow_in;
  logic              zero_in;
  logic              carry;
  logic              overflow;
  logic              zero;

  modport master (
    output ra1, ra2, we3, wa3, wd3,
    output flag_we, carry_in, overflow_in, zero_in,
    input  rd1, rd2, carry, overflow, zero
  );

  modport slave (
    input  ra1, ra2, we3, wa3, wd3,
    input  flag_we, carry_in, overflow_in, zero_in,
    output rd1, rd2, carry, overflow, zero
  );

endinterface

// File: rtl/regfile_flags_status_flags.sv
// status_flags: 3-bit enabled register
// Synchronous active-low clear
module status_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // all three flags load together or hold together
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= 3'b000;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_flags.sv
// regfile_flags: 16x16 register bank plus ALU flags
// r0 reads zero and ignores writes
module regfile_flags
  import regfile_flags_pkg::*;
#(
  parameter int WIDTH  = DATA_MSB,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  regfile_flags_if.slave   bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [WIDTH:0] mem [NREGS];
  logic [2:0]     flag_d;
  logic [2:0]     flag_q;

  // bank update; an X address matches no register, so r0 stays clean
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (bus.we3) begin
      for (int i = 1; i < NREGS; i++)
        if (bus.wa3 == ADDR_W'(i))
          mem[i] <= bus.wd3;
    end
  end

  // zero-latency reads, r0 forced to zero
  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (bus.ra1 != ADDR_W'(REG_ZERO)) bus.rd1 = mem[bus.ra1];
    if (bus.ra2 != ADDR_W'(REG_ZERO)) bus.rd2 = mem[bus.ra2];
  end

  // pack ALU status into the flag vector
  always_comb begin
    flag_d         = '0;
    flag_d[FLAG_C] = bus.carry_in;
    flag_d[FLAG_V] = bus.overflow_in;
    flag_d[FLAG_Z] = bus.zero_in;
  end

  status_flags u_flags (
    .clk   (clk),
    .rst_n (reset),
    .en    (bus.flag_we),
    .d     (flag_d),
    .q     (flag_q)
  );

  // unpack registered flags
  always_comb begin
    bus.carry    = flag_q[FLAG_C];
    bus.overflow = flag_q[FLAG_V];
    bus.zero     = flag_q[FLAG_Z];
  end

endmodule

// File: tb/tb_regfile_flags.sv
// regfile_flags testbench
// Directed table, hand sequences, random vs reference model
module tb_regfile_flags;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  regfile_flags_if bus ();

  regfile_flags dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        fwe;
    logic [2:0]  cvz;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic [2:0]  e_cvz;
  } vec_t;

  vec_t vecs [8];

  logic [15:0] m_mem [16];
  logic [2:0]  m_cvz;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd,
                       input logic fwe, input logic [2:0] cvz,
                       input logic [3:0] a1, input logic [3:0] a2);
    reset           = rst;
    bus.we3         = we;
    bus.wa3         = wa;
    bus.wd3         = wd;
    bus.flag_we     = fwe;
    bus.carry_in    = cvz[2];
    bus.overflow_in = cvz[1];
    bus.zero_in     = cvz[0];
    bus.ra1         = a1;
    bus.ra2         = a2;
  endtask

  task automatic model_edge(input logic rst, input logic we,
                            input logic [3:0] wa, input logic [15:0] wd,
                            input logic fwe, input logic [2:0] cvz);
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = 16'h0;
      m_cvz = 3'b000;
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (fwe) m_cvz = cvz;
    end
  endtask

  function automatic logic [2:0] dut_cvz();
    return {bus.carry, bus.overflow, bus.zero};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{1, 1, 5, 16'h1234, 0, 3'b000, 5, 5, 16'h1234, 16'h1234, 3'b000};
    vecs[1] = '{1, 1, 0, 16'hBEEF, 0, 3'b000, 0, 5, 16'h0000, 16'h1234, 3'b000};
    vecs[2] = '{1, 1, 7, 16'h0042, 0, 3'b000, 7, 0, 16'h0042, 16'h0000, 3'b000};
    vecs[3] = '{1, 0, 7, 16'hAAAA, 0, 3'b000, 7, 7, 16'h0042, 16'h0042, 3'b000};
    vecs[4] = '{1, 0, 0, 16'h0000, 1, 3'b101, 7, 5, 16'h0042, 16'h1234, 3'b101};
    vecs[5] = '{1, 1, 3, 16'h8000, 0, 3'b010, 3, 5, 16'h8000, 16'h1234, 3'b101};
    vecs[6] = '{1, 0, 3, 16'h0000, 1, 3'b010, 3, 7, 16'h8000, 16'h0042, 3'b010};
    vecs[7] = '{0, 1, 9, 16'h5555, 1, 3'b111, 9, 3, 16'h0000, 16'h0000, 3'b000};

    drive(0, 0, 0, 16'h0, 0, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", 32'(bus.rd1), 32'h0);
    chk("reset_flags", 32'(dut_cvz()), 32'h0);

    // read-during-write shows old value before the edge
    drive(1, 1, 5, 16'h1234, 0, 3'b000, 5, 5);
    #1;
    chk("rdw_old", 32'(bus.rd1), 32'h0);
    @(posedge clk);
    #1;
    chk("rdw_new", 32'(bus.rd2), 32'h1234);

    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].rst, vecs[k].we, vecs[k].wa, vecs[k].wd,
            vecs[k].fwe, vecs[k].cvz, vecs[k].ra1, vecs[k].ra2);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd1", k), 32'(bus.rd1), 32'(vecs[k].e_rd1));
      chk($sformatf("vec%0d_rd2", k), 32'(bus.rd2), 32'(vecs[k].e_rd2));
      chk($sformatf("vec%0d_flags", k), 32'(dut_cvz()), 32'(vecs[k].e_cvz));
    end

    // fill r1..r15 with ones and set flags, then reset
    for (int r = 1; r < 16; r++) begin
      drive(1, 1, 4'(r), 16'hFFFF, 1, 3'b111, 4'(r), 0);
      @(posedge clk);
      #1;
    end
    chk("fill_r15", 32'(bus.rd1), 32'hFFFF);
    drive(1, 1, 0, 16'hBEEF, 0, 3'b000, 0, 1);
    @(posedge clk);
    #1;
    chk("r0_write_r0", 32'(bus.rd1), 32'h0);
    chk("r0_write_r1", 32'(bus.rd2), 32'hFFFF);
    drive(0, 0, 0, 16'h0, 0, 3'b000, 0, 0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) begin
      bus.ra1 = 4'(r);
      bus.ra2 = 4'(15 - r);
      #1;
      chk($sformatf("clr_rd1_r%0d", r), 32'(bus.rd1), 32'h0);
      chk($sformatf("clr_rd2_r%0d", r), 32'(bus.rd2), 32'h0);
    end
    chk("clr_flags", 32'(dut_cvz()), 32'h0);

    // random traffic against the model
    foreach (m_mem[i]) m_mem[i] = 16'h0;
    m_cvz = 3'b000;
    for (int n = 0; n < 400; n++) begin
      logic        rs, we, fw;
      logic [3:0]  wa, a1, a2;
      logic [15:0] wd;
      logic [2:0]  cz;
      rs = ($urandom_range(0, 39) != 0);
      we = 1'($urandom);
      fw = 1'($urandom);
      wa = 4'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom);
      wd = 16'($urandom);
      cz = 3'($urandom);
      drive(rs, we, wa, wd, fw, cz, a1, a2);
      #1;
      chk("rnd_pre_rd1", 32'(bus.rd1), 32'(m_mem[a1]));
      model_edge(rs, we, wa, wd, fw, cz);
      @(posedge clk);
      #1;
      chk("rnd_rd1", 32'(bus.rd1), 32'(m_mem[a1]));
      chk("rnd_rd2", 32'(bus.rd2), 32'(m_mem[a2]));
      chk("rnd_flags", 32'(dut_cvz()), 32'(m_cvz));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_flags.md
Name: regfile_flags

Overview:
- Architectural state block directly upstream of the 16-bit ALU in the single-cycle CPU.
- Holds the general-purpose register bank that drives ALU operands a/b and receives the ALU result `y` on writeback.
- Also latches the ALU status outputs (carry, overflow, zero) into a flag register, consumed by the next instruction's branch logic.

Parameters:
- WIDTH, 15, MSB index of a data word (data is WIDTH+1 = 16 bits, same convention as the ALU).
- ADDR_W, 4, register address width; register count = 2**ADDR_W = 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- ra1  input  ADDR_W  read address, port 1 (feeds ALU a).
- ra2  input  ADDR_W  read address, port 2 (feeds ALU b).
- rd1  output  WIDTH+1  read data, port 1.
- rd2  output  WIDTH+1  read data, port 2.
- we3  input  1  register write enable.
- wa3  input  ADDR_W  write address.
- wd3  input  WIDTH+1  write data (ALU y or immediate, muxed outside).
- flag_we  input  1  flag register update enable.
- carry_in  input  1  ALU carry.
- overflow_in  input  1  ALU overflow.
- zero_in  input  1  ALU zero.
- carry  output  1  registered carry flag.
- overflow  output  1  registered overflow flag.
- zero  output  1  registered zero flag.

Behaviour:
- Reset (reset==0 at rising edge):
  - All 16 registers clear to 0.
  - carry, overflow and zero clear to 0.
  - Reset dominates we3/flag_we in the same cycle.
  - While reset is held low, state stays 0; rd1/rd2 read 0.
- Reads: combinational, zero-latency. rdN = mem[raN], and rdN = 0 whenever raN == 0.
- Register 0: hardwired zero.
  - A write with wa3 == 0 is discarded; no other register changes.
  - No X ever propagates from r0.
- Writes: on rising edge with reset==1 and we3==1, mem[wa3] <= wd3.
  - Exactly one register changes per cycle.
  - we3==0: no register changes.
- Read-during-write: same address in the same cycle returns the OLD value until the edge (no bypass); the new value is visible combinationally just after the edge.
  - This suits single-cycle timing, where the write is the current instruction's result.
- Dual read: ra1 == ra2 is legal; both ports return the same value.
- Flags: on rising edge with reset==1 and flag_we==1, {carry, overflow, zero} <= {carry_in, overflow_in, zero_in}.
  - flag_we==0 holds all three flags.
  - The three flags always update together; no partial update.
- Independence: we3 and flag_we are independent; both may be asserted in one cycle, and both updates occur.
- Undefined inputs: X on wa3 with we3==1 is a caller error. The implementation must not corrupt r0 in any case.
- No internal state beyond the 16 registers and 3 flags; no handshake; every operation completes in one cycle.

Decomposition:
- Shared CPU package holds:
  - DATA_MSB = 15, REG_ADDR_W = 4, NUM_REGS = 16.
  - REG_ZERO = 4'd0.
  - A flag-vector bit ordering constant: FLAG_C = 2, FLAG_V = 1, FLAG_Z = 0.
- One sub-module: status_flags, a 3-bit enabled register with synchronous active-low clear, instantiated once. The register array stays in regfile_flags.

Test Plan:
- Reset clear: write 16'hFFFF to r1..r15, then hold reset=0 for one edge → every rdN reads 16'h0000; carry/overflow/zero read 0.
- Basic write/read: we3=1, wa3=5, wd3=16'h1234; next cycle ra1=5, ra2=5 → rd1 = rd2 = 16'h1234. Before the edge, rd1 still shows the old value 16'h0000.
- r0 protection: we3=1, wa3=0, wd3=16'hBEEF → ra1=0 reads 16'h0000; r1..r15 unchanged.
- Write enable off: we3=0, wa3=7, wd3=16'hAAAA → r7 keeps its prior value 16'h0042.
- Flags: flag_we=1 with {c,v,z}=3'b101 → flags read 1,0,1. Next cycle flag_we=0 with inputs 3'b010 → flags stay 1,0,1. Same cycle, we3=1 to r3=16'h8000 → both updates land.
- Reset mid-operation: reset=0 in the same cycle as we3=1 (wa3=9, wd3=16'h5555) and flag_we=1 (3'b111) → r9=0 and flags=000 after the edge.
